// File: rtl/dadda_mul_arbiter_pkg.sv
// Shared types for the Dadda multiplier arbiter.
// Contents:
//   DefWidth/DefNumReq/DefIdw - default operand width, requester count, index width
//   s1_t                      - operand register record {valid, id, a, b}
//   s2_t                      - result register record {valid, id, p}
//   pipe_st_e                 - pipeline occupancy, encoded as {s1_valid, s2_valid}
package dadda_pkg;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefNumReq = 4;
  localparam int unsigned DefIdw    = $clog2(DefNumReq);

  typedef struct packed {
    logic                valid;
    logic [DefIdw-1:0]   id;
    logic [DefWidth-1:0] a;
    logic [DefWidth-1:0] b;
  } s1_t;

  typedef struct packed {
    logic                  valid;
    logic [DefIdw-1:0]     id;
    logic [2*DefWidth-1:0] p;
  } s2_t;

  // Encoding is fixed as {s1_valid, s2_valid} so the state is a cast of the valid bits.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StDrain = 2'b01,
    StIssue = 2'b10,
    StFull  = 2'b11
  } pipe_st_e;

endpackage

// File: rtl/dadda_mul_arbiter_if.sv
// Request/response bundle between the compute units and the arbiter.
// Signals:
//   req_valid/req_ready - per-requester handshake (at most one ready bit high)
//   req_a/req_b         - per-requester operands
//   rsp_valid/rsp_ready - shared response handshake
//   rsp_id/rsp_p        - requester index and 2*WIDTH-bit product
// Modports: master = requesters + response consumer, slave = arbiter.
interface dadda_mul_arbiter_if
  import dadda_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned NUM_REQ = DefNumReq
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [IDW-1:0]                rsp_id;
  logic [2*WIDTH-1:0]            rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/dadda_mul_arbiter_rr_arbiter.sv
// Round-robin grant generator with its rotating priority pointer.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   req        - request vector
//   update_en  - a grant was accepted this cycle; move pointer past the winner
//   grant      - one-hot grant (combinational, independent of any ready)
//   grant_id   - binary index of the granted requester
module rr_arbiter
  import dadda_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update_en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW:0]   idx;  // one spare bit: ptr + offset reaches 2*NUM_REQ-2 before wrap
  logic           found;

  // Scan from ptr upward with wrap; first requester hit wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(off);
      if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
      if (!found && req[idx[IDW-1:0]]) begin
        found                 = 1'b1;
        grant[idx[IDW-1:0]]   = 1'b1;
        grant_id              = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_en) begin
      ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dadda_mul_arbiter.sv
// Shares one external combinational Dadda multiplier between NUM_REQ requesters.
// Two-stage pipeline: S1 operand register drives the multiplier, S2 result register
// holds the product on the shared response channel.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   bus          - request/response bundle (slave side)
//   mul_a/mul_b  - operands to the external multiplier (from S1)
//   mul_p        - combinational product from the external multiplier
//   busy         - either stage holds a valid entry
//   op_count     - completed responses, saturating at 16'hFFFF
// WIDTH/NUM_REQ must match the package defaults, which size the stage records.
module dadda_mul_arbiter
  import dadda_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned NUM_REQ = DefNumReq,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  dadda_mul_arbiter_if.slave   bus,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic                 busy,
  output logic [15:0]          op_count
);

  s1_t                s1_q, s1_d;
  s2_t                s2_q, s2_d;
  logic               s1_adv, s2_adv, hs;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic [15:0]        op_count_q, op_count_d;
  pipe_st_e           pipe_st;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .update_en (hs),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  assign s2_adv        = !s2_q.valid || bus.rsp_ready;
  assign s1_adv        = !s1_q.valid || s2_adv;
  assign bus.req_ready = grant & {NUM_REQ{s1_adv}};
  assign hs            = |(bus.req_valid & bus.req_ready);

  always_comb begin
    s1_d = s1_q;
    if (s1_adv) begin
      if (hs) begin
        s1_d.valid = 1'b1;
        s1_d.id    = grant_id;
        s1_d.a     = bus.req_a[grant_id];
        s1_d.b     = bus.req_b[grant_id];
      end else begin
        // Operands are kept so mul_a/mul_b do not toggle needlessly.
        s1_d.valid = 1'b0;
      end
    end
  end

  always_comb begin
    s2_d = s2_q;
    if (s2_adv) begin
      s2_d.valid = s1_q.valid;
      s2_d.id    = s1_q.id;
      s2_d.p     = mul_p;
    end
  end

  always_comb begin
    op_count_d = op_count_q;
    if (s2_q.valid && bus.rsp_ready && (op_count_q != 16'hFFFF)) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      op_count_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      op_count_q <= op_count_d;
    end
  end

  assign pipe_st       = pipe_st_e'({s1_q.valid, s2_q.valid});
  assign busy          = (pipe_st != StEmpty);
  assign mul_a         = s1_q.a;
  assign mul_b         = s1_q.b;
  assign bus.rsp_valid = s2_q.valid;
  assign bus.rsp_id    = s2_q.id;
  assign bus.rsp_p     = s2_q.p;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Directed bench for dadda_mul_arbiter; the external multiplier is modelled inline.
module tb_dadda_mul_arbiter;

  logic        clk;
  logic        rst;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;
  logic        busy;
  logic [15:0] op_count;

  int n_vec = 0;
  int n_err = 0;

  dadda_mul_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) bus ();

  dadda_mul_arbiter #(
    .WIDTH   (8),
    .NUM_REQ (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_p    (mul_p),
    .busy     (busy),
    .op_count (op_count)
  );

  assign mul_p = mul_a * mul_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_p", bus.rsp_p, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_req_ready", bus.req_ready, 0);

    // Single op: 255*255
    bus.req_valid = 4'b0001;
    bus.req_a[0]  = 8'd255;
    bus.req_b[0]  = 8'd255;
    #1;
    check("one_req_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    #1;
    check("one_mul_a", mul_a, 8'd255);
    check("one_busy_s1", busy, 1);
    check("one_not_yet", bus.rsp_valid, 0);
    tick();
    #1;
    check("one_rsp_valid", bus.rsp_valid, 1);
    check("one_rsp_id", bus.rsp_id, 0);
    check("one_rsp_p", bus.rsp_p, 16'hFE01);
    tick();
    #1;
    check("one_drained", bus.rsp_valid, 0);
    check("one_busy_low", busy, 0);
    check("one_count", op_count, 1);

    // Reset pulse so the pointer starts at 0 for the round-robin run
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst2_count", op_count, 0);

    // Round-robin: a_i = i+1, b_i = 3
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i] = 8'(i + 1);
      bus.req_b[i] = 8'd3;
    end
    for (int k = 0; k < 10; k++) begin
      bus.req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) check("rr_grant", bus.req_ready, 32'd1 << (k % 4));
      if (k >= 2) begin
        check("rr_valid", bus.rsp_valid, 1);
        check("rr_id", bus.rsp_id, (k - 2) % 4);
        check("rr_p", bus.rsp_p, 3 * ((k - 2) % 4 + 1));
      end
      tick();
    end
    #1;
    check("rr_drained", bus.rsp_valid, 0);
    check("rr_count", op_count, 8);

    // Backpressure: fill both stages, stall 5 cycles
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0011;
    bus.req_a[0]  = 8'd10;
    bus.req_b[0]  = 8'd20;
    bus.req_a[1]  = 8'd7;
    bus.req_b[1]  = 8'd9;
    #1;
    check("bp_grant0", bus.req_ready, 4'b0001);
    tick();
    #1;
    check("bp_grant1", bus.req_ready, 4'b0010);
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_stall_ready", bus.req_ready, 0);
      check("bp_stall_valid", bus.rsp_valid, 1);
      check("bp_stall_id", bus.rsp_id, 0);
      check("bp_stall_p", bus.rsp_p, 200);
      tick();
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = '0;
    #1;
    check("bp_out0_id", bus.rsp_id, 0);
    check("bp_out0_p", bus.rsp_p, 200);
    tick();
    #1;
    check("bp_out1_valid", bus.rsp_valid, 1);
    check("bp_out1_id", bus.rsp_id, 1);
    check("bp_out1_p", bus.rsp_p, 63);
    tick();
    #1;
    check("bp_drained", bus.rsp_valid, 0);
    check("bp_count", op_count, 10);

    // Pointer hold: pointer is 2 here; requester 2 fills both stages
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    bus.req_a[2]  = 8'd5;
    bus.req_b[2]  = 8'd5;
    #1;
    check("ph_grant2a", bus.req_ready, 4'b0100);
    tick();
    bus.req_a[2] = 8'd6;
    bus.req_b[2] = 8'd6;
    #1;
    check("ph_grant2b", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = 4'b0010;
    bus.req_a[1]  = 8'd4;
    bus.req_b[1]  = 8'd4;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ph_stall_ready", bus.req_ready, 0);
      check("ph_stall_p", bus.rsp_p, 25);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("ph_grant1", bus.req_ready, 4'b0010);
    check("ph_out0_id", bus.rsp_id, 2);
    check("ph_out0_p", bus.rsp_p, 25);
    tick();
    // Pointer now 2: with 1,2,3 requesting, 2 must win
    bus.req_valid = 4'b1110;
    #1;
    check("ph_ptr_is_2", bus.req_ready, 4'b0100);
    check("ph_out1_p", bus.rsp_p, 36);
    tick();
    bus.req_valid = '0;
    #1;
    check("ph_out2_id", bus.rsp_id, 1);
    check("ph_out2_p", bus.rsp_p, 16);
    tick();
    #1;
    check("ph_out3_id", bus.rsp_id, 2);
    check("ph_out3_p", bus.rsp_p, 36);
    tick();
    #1;
    check("ph_drained", bus.rsp_valid, 0);
    check("ph_count", op_count, 14);

    // Reset one cycle after an accept
    bus.req_valid = 4'b0001;
    bus.req_a[0]  = 8'd3;
    bus.req_b[0]  = 8'd3;
    tick();
    bus.req_valid = '0;
    rst           = 1'b1;
    tick();
    #1;
    check("mr_rsp_valid", bus.rsp_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_count", op_count, 0);
    rst = 1'b0;
    tick();
    tick();
    #1;
    check("mr_no_rsp", bus.rsp_valid, 0);

    // Saturation: requester 0 streams one op per cycle
    bus.req_valid = 4'b0001;
    repeat (65536) tick();
    #1;
    check("sat_fffe", op_count, 16'hFFFE);
    tick();
    #1;
    check("sat_ffff", op_count, 16'hFFFF);
    repeat (4) tick();
    #1;
    check("sat_hold", op_count, 16'hFFFF);
    bus.req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dadda_mul_arbiter.md
# dadda_mul_arbiter

Round-robin arbiter and two-stage pipeline sequencer that shares one combinational WIDTH×WIDTH Dadda multiplier between NUM_REQ requesters. Accepted operands go into an operand register that drives the multiplier. The product is captured into a result register and returned on a single shared response channel tagged with the requester index. The block sits between the requesting compute units and the multiplier instance, and owns all valid/ready flow control around it.

## Interface
- WIDTH, 8, operand width; product is 2*WIDTH bits.
- NUM_REQ, 4, number of requesters (≥2).
- IDW, $clog2(NUM_REQ), requester-index width.
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand-valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  input  NUM_REQ×WIDTH  per-requester multiplicand.
- req_b  input  NUM_REQ×WIDTH  per-requester multiplier.
- mul_a  output  WIDTH  to multiplier in1, driven from the operand register.
- mul_b  output  WIDTH  to multiplier in2, driven from the operand register.
- mul_p  input  2*WIDTH  combinational product from the multiplier.
- rsp_valid  output  1  result register holds a valid product.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that issued this product.
- rsp_p  output  2*WIDTH  product.
- busy  output  1  either pipeline stage is valid.
- op_count  output  16  completed responses (rsp_valid&&rsp_ready), saturates at 16'hFFFF.

## Operation
- Stage S1 (operand register): s1_valid, s1_id, s1_a, s1_b. mul_a=s1_a, mul_b=s1_b.
- Stage S2 (result register): s2_valid=rsp_valid, s2_id=rsp_id, s2_p=rsp_p.
- s2_adv = !s2_valid || rsp_ready. s1_adv = !s1_valid || s2_adv.
- Arbitration: grant = first i with req_valid[i], searching from rr_ptr upward with wrap NUM_REQ-1→0. req_ready[i] = grant[i] && s1_adv. A grant is combinational and never depends on req_ready.
- Handshake on req_valid[g]&&req_ready[g]: load S1 with {1, g, req_a[g], req_b[g]}. rr_ptr ← (g+1) mod NUM_REQ. rr_ptr is unchanged in cycles without a handshake.
- When s1_adv is true and no handshake occurs, s1_valid ← 0.
- When s2_adv is true, S2 ← {s1_valid, s1_id, mul_p}.
- While stalled (rsp_valid && !rsp_ready), S1 and S2 hold, req_ready is all-zero, and rsp_id/rsp_p stay stable.
- Unsigned arithmetic only. Product width is 2*WIDTH, with no truncation.
- The FSM is implicit in the {s1_valid, s2_valid} pair: EMPTY(00), ISSUE(10), DRAIN(01), FULL(11). Transitions follow from the advance equations.

## Timing
- Reset: s1_valid=0, s2_valid=0, rr_ptr=0, S1/S2 data=0, op_count=0. Therefore rsp_valid=0, rsp_id=0, rsp_p=0, mul_a=mul_b=0, busy=0. req_ready is combinational and is 0 when req_valid is all-zero.
- Latency: a handshake in cycle N gives rsp_valid in cycle N+2, provided there is no backpressure.
- Throughput: one operation per cycle while rsp_ready=1.
- A simultaneous response pop and new accept in the same cycle is legal. In FULL with rsp_ready=1, both stages shift and one new request is accepted.
- A requester that holds req_valid is served within NUM_REQ accepts (fairness bound).
- A single requester gets back-to-back grants every cycle.
- Reset mid-operation discards both stages and emits no response. op_count clears.
- op_count increments on rsp_valid&&rsp_ready and holds at 16'hFFFF.

## Structure
- Package dadda_pkg holds: default WIDTH/NUM_REQ constants, the typedef of the S1 record {valid, id, a, b}, and the typedef of the S2 record {valid, id, p}.
- Sub-module rr_arbiter#(NUM_REQ) contains the combinational priority rotate plus the rr_ptr register. Its update_en input is tied to the handshake.
- The top module holds the pipeline registers, advance logic, and counter. The multiplier is instantiated outside the block by the integrator.

## Test plan
- Single op: req_valid=4'b0001, a=8'd255, b=8'd255 for one cycle -> rsp_valid two cycles later, rsp_id=0, rsp_p=16'hFE01, busy drops the following cycle.
- Round-robin: all four requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,… and responses each cycle with matching rsp_id. For a_i=i+1, b_i=3, products are 3,6,9,12.
- Backpressure: fill both stages, hold rsp_ready=0 for 5 cycles -> req_ready=0, rsp_p/rsp_id stable. Release -> both results delivered in order on consecutive cycles, with no loss or duplication.
- Pointer hold: requester 2 wins, then only requester 1 is valid while stalled -> no grant. After release, requester 1 is granted and rr_ptr advances to 2.
- Reset mid-flight: assert rst one cycle after an accept -> next cycle rsp_valid=0, busy=0, op_count=0. No response for the discarded op.
- Counter saturation: force 65537 completions (or preload via backdoor) -> op_count holds at 16'hFFFF.
